interrupt_trap_unit: RTL and testbench
======================================

# interrupt_trap_unit

Trap and interrupt sequencer sitting directly downstream of the single-cycle controller: it consumes the decoded `ecall`, `uret`, `csrrsi` and `csrrci` flags, owns the interrupt-enable, EPC and pending state, and drives the PC-redirect path of the datapath. It supports three prioritised external interrupt lines plus the `ecall` trap, with one level of service and no nesting. Every cycle commits one instruction, so all trap decisions are made at instruction boundaries.

## Interface

Parameters:
- `VEC_ECALL`, 32'h0000_0100: handler address for `ecall`.
- `VEC_IRQ0`, 32'h0000_0200: handler address for irq[0].
- `VEC_IRQ1`, 32'h0000_0300: handler address for irq[1].
- `VEC_IRQ2`, 32'h0000_0400: handler address for irq[2].

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock, same as the PC/register file.
- `rst`  in  1  synchronous, active-high reset.
- `halt`  in  1  CPU halted; no trap taken, architectural state held.
- `ecall`  in  1  from controller; current instruction is ecall.
- `uret`  in  1  from controller; current instruction is uret.
- `csrrsi`  in  1  from controller; set IE if `zimm[0]`.
- `csrrci`  in  1  from controller; clear IE if `zimm[0]`.
- `zimm`  in  5  IR[19:15].
- `npc`  in  32  next PC the datapath would load this cycle.
- `irq`  in  3  synchronised interrupt request lines, level.
- `redirect`  out  1  PC must load `redirect_pc` at the next edge.
- `redirect_pc`  out  32  handler vector or EPC.
- `csr_rdata`  out  32  {31'b0, ie}: old IE value, written to rd by csrrsi/csrrci.
- `in_service`  out  1  handler active.
- `pending`  out  3  latched pending requests.
- `cause`  out  2  0 = ecall, 1..3 = irq0..irq2 (last trap taken).

## Operation

- State registers: `ie`, `saved_ie`, `epc[31:0]`, `in_service`, `pending[2:0]`, `irq_prev[2:0]`, `cause[1:0]`.
- Edge capture: `pending[i]` set when `irq[i] & ~irq_prev[i]`; `irq_prev <= irq` every cycle, including during `halt`. Holding a level does not re-trigger.
- Eligible interrupt: `ie & ~in_service & ~halt & |pending`. Priority irq2 > irq1 > irq0.
- Decision per cycle (combinational, first match wins):
  1. `halt`: `redirect`=0.
  2. `uret` with `in_service`=1: `redirect`=1, `redirect_pc`=`epc`; at edge: `in_service`<=0, `ie`<=`saved_ie`.
  3. `ecall` with `in_service`=0: `redirect`=1, `redirect_pc`=`VEC_ECALL`, `cause`<=0.
  4. Eligible interrupt i: `redirect`=1, `redirect_pc`=`VEC_IRQi`, `cause`<=i+1, `pending[i]`<=0.
  5. Else `redirect`=0, `redirect_pc`=`npc`.
- Trap entry (cases 3, 4): `epc`<=`npc`, `saved_ie`<=IE value after this cycle's csr update, `ie`<=0, `in_service`<=1.
- CSR update: `csrrsi & zimm[0]` sets `ie`; `csrrci & zimm[0]` clears it; applies only when not overridden by trap entry or uret.
- `uret` while not in service and `ecall` while in service: no-ops (no redirect, no state change).
- Pending clear and new edge on the same line in the same cycle: pending stays 1.

## Timing

- Reset: `ie`=0, `saved_ie`=0, `epc`=0, `in_service`=0, `pending`=0, `irq_prev`=0, `cause`=0; thus `redirect`=0, `redirect_pc`=`npc`, `csr_rdata`=0.
- Rising edge on irq[i] sampled at edge N; `pending[i]`=1 after N; with `ie`=1 and not in service, `redirect` high during cycle N+1; PC holds vector after edge N+1.
- `ecall`/`uret` redirect in the same cycle the instruction executes (zero added latency).
- `redirect`/`redirect_pc` depend combinationally on registered state and current-cycle inputs; no combinational path from `irq`.
- `rst` mid-handler: all state cleared at that edge; pending requests discarded.

## Test plan

- Reset, then `csrrsi` zimm=1, pulse irq[1] at npc=0x40 -> one cycle later `redirect`=1, `redirect_pc`=0x300, `epc`=0x40, `cause`=2, `ie`=0, `in_service`=1.
- In handler, `uret` -> `redirect_pc`=0x40; next cycle `in_service`=0, `ie`=1.
- irq[0] and irq[2] edges in same cycle with `ie`=1 -> 0x400 taken first; after `uret`, 0x200 taken next cycle; `pending` reads 3'b001 between.
- `ie`=0, irq[2] edge -> `pending`=3'b100, no redirect; `csrrsi` zimm=1 at npc=0x80 -> next cycle redirect to 0x400 with `epc`=that cycle's npc.
- `ecall` at npc=0x24 same cycle as eligible irq[0] -> redirect 0x100, `cause`=0, `pending[0]` stays 1; `ecall` while in service -> no redirect.
- Assert `rst` while `in_service`=1 and `pending`=3'b011 -> all state zero next cycle; `halt`=1 with pending and `ie`=1 -> no redirect.

Source files
------------

// File: rtl/interrupt_trap_unit.sv
// Trap/interrupt sequencer: owns IE, EPC and pending state, decides at every
// instruction boundary whether the PC is redirected to a handler or back to EPC.
module interrupt_trap_unit #(
    parameter logic [31:0] VEC_ECALL = 32'h0000_0100,
    parameter logic [31:0] VEC_IRQ0  = 32'h0000_0200,
    parameter logic [31:0] VEC_IRQ1  = 32'h0000_0300,
    parameter logic [31:0] VEC_IRQ2  = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        ecall,
    input  logic        uret,
    input  logic        csrrsi,
    input  logic        csrrci,
    input  logic [4:0]  zimm,
    input  logic [31:0] npc,
    input  logic [2:0]  irq,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] csr_rdata,
    output logic        in_service,
    output logic [2:0]  pending,
    output logic [1:0]  cause
);

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_URET,
        ACT_ECALL,
        ACT_IRQ
    } action_t;

    logic        ie_reg, ie_next;
    logic        saved_ie_reg, saved_ie_next;
    logic [31:0] epc_reg, epc_next;
    logic        in_service_reg, in_service_next;
    logic [2:0]  pending_reg, pending_next;
    logic [2:0]  irq_prev_reg;
    logic [1:0]  cause_reg, cause_next;

    logic [2:0]  irq_edge;
    logic [2:0]  clear_mask;
    logic        ie_csr;
    logic        irq_eligible;
    logic [1:0]  irq_sel;
    action_t     action;

    // A request is latched only on a rising edge, so a held level fires once.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_edge
            assign irq_edge[gi] = irq[gi] & ~irq_prev_reg[gi];
        end
    endgenerate

    always_comb begin
        ie_csr = ie_reg;
        if (csrrsi && zimm[0]) ie_csr = 1'b1;
        if (csrrci && zimm[0]) ie_csr = 1'b0;
    end

    assign irq_eligible = ie_reg & ~in_service_reg & ~halt & (|pending_reg);

    always_comb begin
        irq_sel = 2'd0;
        if (pending_reg[2])      irq_sel = 2'd2;
        else if (pending_reg[1]) irq_sel = 2'd1;
    end

    always_comb begin
        action = ACT_NONE;
        if (halt)                           action = ACT_NONE;
        else if (uret && in_service_reg)    action = ACT_URET;
        else if (ecall && !in_service_reg)  action = ACT_ECALL;
        else if (irq_eligible)              action = ACT_IRQ;
    end

    always_comb begin
        redirect        = 1'b0;
        redirect_pc     = npc;
        ie_next         = ie_reg;
        saved_ie_next   = saved_ie_reg;
        epc_next        = epc_reg;
        in_service_next = in_service_reg;
        cause_next      = cause_reg;
        clear_mask      = 3'b000;

        case (action)
            ACT_URET: begin
                redirect        = 1'b1;
                redirect_pc     = epc_reg;
                in_service_next = 1'b0;
                ie_next         = saved_ie_reg;
            end
            ACT_ECALL, ACT_IRQ: begin
                redirect        = 1'b1;
                epc_next        = npc;
                saved_ie_next   = ie_csr;
                ie_next         = 1'b0;
                in_service_next = 1'b1;
                if (action == ACT_ECALL) begin
                    redirect_pc = VEC_ECALL;
                    cause_next  = 2'd0;
                end else begin
                    case (irq_sel)
                        2'd2:    redirect_pc = VEC_IRQ2;
                        2'd1:    redirect_pc = VEC_IRQ1;
                        default: redirect_pc = VEC_IRQ0;
                    endcase
                    cause_next          = irq_sel + 2'd1;
                    clear_mask[irq_sel] = 1'b1;
                end
            end
            default: begin
                // Halt freezes architectural state, including IE writes.
                if (!halt) ie_next = ie_csr;
            end
        endcase
    end

    // A fresh edge wins over a same-cycle clear so no request is lost.
    assign pending_next = (pending_reg & ~clear_mask) | irq_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            ie_reg         <= 1'b0;
            saved_ie_reg   <= 1'b0;
            epc_reg        <= 32'd0;
            in_service_reg <= 1'b0;
            pending_reg    <= 3'b000;
            irq_prev_reg   <= 3'b000;
            cause_reg      <= 2'd0;
        end else begin
            ie_reg         <= ie_next;
            saved_ie_reg   <= saved_ie_next;
            epc_reg        <= epc_next;
            in_service_reg <= in_service_next;
            pending_reg    <= pending_next;
            irq_prev_reg   <= irq;
            cause_reg      <= cause_next;
        end
    end

    assign csr_rdata  = {31'd0, ie_reg};
    assign in_service = in_service_reg;
    assign pending    = pending_reg;
    assign cause      = cause_reg;

endmodule

// File: tb/tb_interrupt_trap_unit.sv
// Directed bench for interrupt_trap_unit: inputs change 1ns after the rising
// edge, outputs are compared on the falling edge against hand-computed values.
module tb_interrupt_trap_unit;

    logic        clk = 1'b0;
    logic        rst, halt, ecall, uret, csrrsi, csrrci;
    logic [4:0]  zimm;
    logic [31:0] npc;
    logic [2:0]  irq;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] csr_rdata;
    logic        in_service;
    logic [2:0]  pending;
    logic [1:0]  cause;

    int n_cmp = 0;
    int n_bad = 0;

    interrupt_trap_unit dut (
        .clk         (clk),
        .rst         (rst),
        .halt        (halt),
        .ecall       (ecall),
        .uret        (uret),
        .csrrsi      (csrrsi),
        .csrrci      (csrrci),
        .zimm        (zimm),
        .npc         (npc),
        .irq         (irq),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .csr_rdata   (csr_rdata),
        .in_service  (in_service),
        .pending     (pending),
        .cause       (cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge of the current cycle for sampling.
    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0; ecall = 1'b0; uret = 1'b0;
        csrrsi = 1'b0; csrrci = 1'b0; zimm = 5'd0; npc = 32'h1234; irq = 3'b000;
        tick(); tick();
        sample();
        check("rst_redirect", {31'd0, redirect}, 32'd0);
        check("rst_pc_is_npc", redirect_pc, 32'h1234);
        check("rst_csr_rdata", csr_rdata, 32'd0);
        check("rst_in_service", {31'd0, in_service}, 32'd0);
        check("rst_pending", {29'd0, pending}, 32'd0);
        check("rst_cause", {30'd0, cause}, 32'd0);

        // Enable interrupts, then pulse irq[1].
        tick(); rst = 1'b0; csrrsi = 1'b1; zimm = 5'd1; npc = 32'h10;
        tick(); csrrsi = 1'b0; zimm = 5'd0; irq = 3'b010; npc = 32'h40;
        sample();
        check("t1_ie_set", csr_rdata, 32'd1);
        check("t1_no_comb_irq", {31'd0, redirect}, 32'd0);
        tick(); irq = 3'b000;
        sample();
        check("t1_pending", {29'd0, pending}, 32'b010);
        check("t1_redirect", {31'd0, redirect}, 32'd1);
        check("t1_vec", redirect_pc, 32'h300);
        tick(); npc = 32'h300;
        sample();
        check("t1_cause", {30'd0, cause}, 32'd2);
        check("t1_in_service", {31'd0, in_service}, 32'd1);
        check("t1_ie_cleared", csr_rdata, 32'd0);
        check("t1_pending_clr", {29'd0, pending}, 32'd0);
        check("t1_no_redirect", {31'd0, redirect}, 32'd0);
        tick(); uret = 1'b1; npc = 32'h304;
        sample();
        check("t2_uret_redirect", {31'd0, redirect}, 32'd1);
        check("t2_uret_epc", redirect_pc, 32'h40);
        tick(); uret = 1'b0; npc = 32'h44;
        sample();
        check("t2_out_of_service", {31'd0, in_service}, 32'd0);
        check("t2_ie_restored", csr_rdata, 32'd1);

        // irq[0] and irq[2] together: irq2 first, irq0 right after uret.
        tick(); irq = 3'b101; npc = 32'h50;
        tick(); irq = 3'b000;
        sample();
        check("t3_pending_both", {29'd0, pending}, 32'b101);
        check("t3_vec_irq2", redirect_pc, 32'h400);
        tick(); npc = 32'h400;
        sample();
        check("t3_pending_between", {29'd0, pending}, 32'b001);
        check("t3_cause_irq2", {30'd0, cause}, 32'd3);
        check("t3_no_nesting", {31'd0, redirect}, 32'd0);
        tick(); uret = 1'b1;
        sample();
        check("t3_uret_epc", redirect_pc, 32'h50);
        tick(); uret = 1'b0; npc = 32'h60;
        sample();
        check("t3_irq0_redirect", {31'd0, redirect}, 32'd1);
        check("t3_vec_irq0", redirect_pc, 32'h200);
        tick(); npc = 32'h200;
        sample();
        check("t3_cause_irq0", {30'd0, cause}, 32'd1);
        check("t3_pending_empty", {29'd0, pending}, 32'd0);
        tick(); uret = 1'b1;
        sample();
        check("t3_uret2_epc", redirect_pc, 32'h60);

        // Disabled interrupt stays pending until csrrsi enables it.
        tick(); uret = 1'b0; csrrci = 1'b1; zimm = 5'd1; npc = 32'h70;
        tick(); csrrci = 1'b0; zimm = 5'd0; irq = 3'b100;
        sample();
        check("t4_ie_cleared", csr_rdata, 32'd0);
        tick(); irq = 3'b000;
        sample();
        check("t4_pending", {29'd0, pending}, 32'b100);
        check("t4_masked", {31'd0, redirect}, 32'd0);
        tick(); csrrsi = 1'b1; zimm = 5'd1; npc = 32'h80;
        sample();
        check("t4_enable_cycle", {31'd0, redirect}, 32'd0);
        tick(); csrrsi = 1'b0; zimm = 5'd0; npc = 32'h84;
        sample();
        check("t4_redirect", {31'd0, redirect}, 32'd1);
        check("t4_vec", redirect_pc, 32'h400);
        tick(); uret = 1'b1; npc = 32'h404;
        sample();
        check("t4_epc", redirect_pc, 32'h84);
        tick(); uret = 1'b0;
        sample();
        check("t4_saved_ie", csr_rdata, 32'd1);

        // ecall beats an eligible irq[0]; ecall in service is a no-op.
        irq = 3'b001;
        tick(); irq = 3'b000; ecall = 1'b1; npc = 32'h24;
        sample();
        check("t5_ecall_redirect", {31'd0, redirect}, 32'd1);
        check("t5_ecall_vec", redirect_pc, 32'h100);
        tick(); npc = 32'h100;
        sample();
        check("t5_cause_ecall", {30'd0, cause}, 32'd0);
        check("t5_pending_kept", {29'd0, pending}, 32'b001);
        check("t5_ecall_nested", {31'd0, redirect}, 32'd0);
        tick(); ecall = 1'b0; irq = 3'b010;
        tick(); irq = 3'b000;
        sample();
        check("t6_pending_two", {29'd0, pending}, 32'b011);
        check("t6_still_service", {31'd0, in_service}, 32'd1);

        // Reset mid-handler discards everything.
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; npc = 32'h8;
        sample();
        check("t6_rst_service", {31'd0, in_service}, 32'd0);
        check("t6_rst_pending", {29'd0, pending}, 32'd0);
        check("t6_rst_ie", csr_rdata, 32'd0);
        check("t6_rst_redirect", {31'd0, redirect}, 32'd0);

        // Halt blocks an eligible interrupt and freezes IE.
        tick(); csrrsi = 1'b1; zimm = 5'd1;
        tick(); csrrsi = 1'b0; zimm = 5'd0; irq = 3'b100;
        tick(); irq = 3'b000; halt = 1'b1; csrrci = 1'b1; zimm = 5'd1; npc = 32'hC0;
        sample();
        check("t7_halt_redirect", {31'd0, redirect}, 32'd0);
        check("t7_halt_pc", redirect_pc, 32'hC0);
        tick(); csrrci = 1'b0; zimm = 5'd0;
        sample();
        check("t7_halt_pending", {29'd0, pending}, 32'b100);
        check("t7_halt_ie_held", csr_rdata, 32'd1);
        check("t7_halt_no_service", {31'd0, in_service}, 32'd0);
        tick(); halt = 1'b0;
        sample();
        check("t7_release_vec", redirect_pc, 32'h400);
        check("t7_release_redirect", {31'd0, redirect}, 32'd1);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
